// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream plus RAM-side bus of the FIFO controller.
// With RAM_FIFO_CTRL_ERR_FLAGS_EN defined, the sticky overflow/underflow flags are added.
interface ram_fifo_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int DEPTH_LOG = $clog2(DEPTH);

  // Handshake: a push is taken on a posedge where wr_en=1 and full=0, and a pop where
  // rd_en=1 and empty=0. full/empty act as the ready signals for the two sides.
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 full;
  logic                 rd_en;
  logic [WIDTH-1:0]     rd_data;
  logic                 empty;
  logic [DEPTH_LOG:0]   count;
  logic                 ram_we_n;
  logic [DEPTH_LOG-1:0] ram_addr_wr;
  logic [WIDTH-1:0]     ram_data_wr;
  logic [DEPTH_LOG-1:0] ram_addr_rd;
  logic [WIDTH-1:0]     ram_data_rd;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
  logic                 overflow;
  logic                 underflow;
`endif

  modport master (
    output wr_en, wr_data, rd_en, ram_data_rd,
    input  full, rd_data, empty, count, ram_we_n, ram_addr_wr, ram_data_wr, ram_addr_rd
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ram_data_rd,
    output full, rd_data, empty, count, ram_we_n, ram_addr_wr, ram_data_wr, ram_addr_rd
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller driving an external async-read dual-port RAM.
// Optional sticky overflow/underflow flags under RAM_FIFO_CTRL_ERR_FLAGS_EN.
module ram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic           clk,
  input logic           rst,
  ram_fifo_ctrl_if.slave bus
);
  localparam int DEPTH_LOG = $clog2(DEPTH);
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] ONE      = (DEPTH_LOG+1)'(1);

  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0] count_q, count_d;
  logic               full, empty, push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Reset suppresses the RAM write strobe so a discarded push never touches memory.
  assign push_ok = bus.wr_en & ~full & ~rst;
  assign pop_ok  = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d  = overflow_q  | (bus.wr_en & full);
    underflow_d = underflow_q | (bus.rd_en & empty);
  end
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`endif
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.ram_we_n    = ~push_ok;
  assign bus.ram_addr_wr = wr_ptr_q[DEPTH_LOG-1:0];
  assign bus.ram_data_wr = bus.wr_data;
  assign bus.ram_addr_rd = rd_ptr_q[DEPTH_LOG-1:0];
  assign bus.rd_data     = bus.ram_data_rd;
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, queue-based reference, directed plan and random traffic.
module tb_ram_fifo_ctrl;
  localparam int W = 8;
  localparam int D = 16;
  localparam int DL = $clog2(D);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus ();
  ram_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  // External RAM: write on posedge when strobe low, combinational read.
  logic [W-1:0] mem [D];
  always @(posedge clk) if (!bus.ram_we_n) mem[bus.ram_addr_wr] <= bus.ram_data_wr;
  assign bus.ram_data_rd = mem[bus.ram_addr_rd];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, pointers as running totals.
  logic [W-1:0] exp_q[$];
  int wr_total = 0;
  int rd_total = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always @(posedge clk) begin
    int sz;
    bit do_push, do_pop;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      wr_total = 0;
      rd_total = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      do_push = bus.wr_en && (sz < D);
      do_pop  = bus.rd_en && (sz > 0);
      if (bus.wr_en && sz == D) m_ovf = 1'b1;
      if (bus.rd_en && sz == 0) m_unf = 1'b1;
      if (do_pop) begin
        void'(exp_q.pop_front());
        rd_total++;
      end
      if (do_push) begin
        exp_q.push_back(bus.wr_data);
        wr_total++;
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    bit exp_push;
    if (chk_en) begin
      sz = exp_q.size();
      exp_push = bus.wr_en && (sz < D) && !rst;
      chk("count", 32'(bus.count), 32'(sz));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("full", 32'(bus.full), 32'(sz == D));
      chk("ram_we_n", 32'(bus.ram_we_n), 32'(!exp_push));
      chk("ram_addr_wr", 32'(bus.ram_addr_wr), 32'(wr_total % D));
      chk("ram_addr_rd", 32'(bus.ram_addr_rd), 32'(rd_total % D));
      if (exp_push) chk("ram_data_wr", 32'(bus.ram_data_wr), 32'(bus.wr_data));
      if (sz > 0) chk("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    end
  end

  // One clock with the given inputs, then back to idle just after the edge.
  task automatic cyc(input bit we, input logic [W-1:0] wd, input bit re);
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.rd_en = re;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset(input bit we);
    rst = 1'b1;
    bus.wr_en = we;
    bus.wr_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    for (int i = 0; i < D; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_we_n", 32'(bus.ram_we_n), 32'd1);

    // Single word round trip.
    cyc(1'b1, 8'hA5, 1'b0);
    @(negedge clk);
    chk("one_rd_data", 32'(bus.rd_data), 32'hA5);
    chk("one_empty", 32'(bus.empty), 32'd0);
    chk("one_count", 32'(bus.count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("one_pop_empty", 32'(bus.empty), 32'd1);
    chk("one_pop_count", 32'(bus.count), 32'd0);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(i), 1'b0);
    @(negedge clk);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hFF;
    @(negedge clk);
    chk("ovf_we_n", 32'(bus.ram_we_n), 32'd1);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("drain_data", 32'(bus.rd_data), 32'(i));
      cyc(1'b0, 8'h00, 1'b1);
    end
    @(negedge clk);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Full with push and pop together: only the pop is taken.
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    @(negedge clk);
    chk("fullpp_count", 32'(bus.count), 32'd15);
    chk("fullpp_rd_data", 32'(bus.rd_data), 32'h01);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("fullpp_drained", 32'(bus.empty), 32'd1);

    // Empty with push and pop together: only the push is taken, then streaming.
    cyc(1'b1, 8'h3C, 1'b1);
    @(negedge clk);
    chk("emptypp_count", 32'(bus.count), 32'd1);
    chk("emptypp_rd_data", 32'(bus.rd_data), 32'h3C);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1);
    @(negedge clk);
    chk("stream_count", 32'(bus.count), 32'd1);
    chk("stream_rd_data", 32'(bus.rd_data), 32'h67);
    cyc(1'b0, 8'h00, 1'b1);

    // Reset mid-stream, with a push attempted during reset.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset(1'b1);
    @(negedge clk);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_addr_wr", 32'(bus.ram_addr_wr), 32'd0);

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
    cyc(1'b0, 8'h00, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("unf_sticky", 32'(bus.underflow), 32'd1);
    chk("unf_no_ovf", 32'(bus.overflow), 32'd0);
    do_reset(1'b0);
    @(negedge clk);
    chk("unf_cleared", 32'(bus.underflow), 32'd0);
`endif

    // Random traffic in phases biased toward filling, draining and balance.
    for (int ph = 0; ph < 6; ph++) begin
      int wb, rb;
      wb = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      rb = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1'($urandom_range(0, 1)));
        end else begin
          cyc(($urandom_range(0, 99) < wb), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 99) < rb));
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller placed directly upstream of the dual-port async-read RAM (8-bit × 16 default).
- Converts a push/pop stream interface into RAM write strobe, write address/data and read address.
- Returns the RAM's combinational read data to the consumer as first-word-fall-through output.
- Tracks occupancy and drives full/empty; the RAM itself stays a separate instance.

Parameters:
- WIDTH, 8, data word width; must match the RAM WIDTH.
- DEPTH, 16, FIFO entries; must match the RAM DEPTH; power of 2, ≥ 2.
- DEPTH_LOG, $clog2(DEPTH), address width (localparam, derived).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- wr_en  in  1  push request.
- wr_data  in  WIDTH  push data.
- full  out  1  high when count == DEPTH.
- rd_en  in  1  pop request.
- rd_data  out  WIDTH  head-of-FIFO data (FWFT).
- empty  out  1  high when count == 0.
- count  out  DEPTH_LOG+1  current occupancy, 0..DEPTH.
- ram_we_n  out  1  RAM write strobe, active-low; RAM writes on posedge clk when 0.
- ram_addr_wr  out  DEPTH_LOG  RAM write address.
- ram_data_wr  out  WIDTH  RAM write data.
- ram_addr_rd  out  DEPTH_LOG  RAM read address.
- ram_data_rd  in  WIDTH  RAM async read data.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, ram_we_n=1.
  - Any push or pop in that cycle is discarded.
  - Reset mid-operation discards all stored entries; RAM contents are not cleared but become unreachable.
- Push accept: push_ok = wr_en & ~full.
  - Combinationally: ram_we_n = ~push_ok, ram_addr_wr = wr_ptr[DEPTH_LOG-1:0], ram_data_wr = wr_data.
  - At posedge: RAM stores the word and wr_ptr increments.
- Pop accept: pop_ok = rd_en & ~empty.
  - ram_addr_rd = rd_ptr[DEPTH_LOG-1:0] at all times.
  - rd_data = ram_data_rd, passed through combinationally.
  - At posedge with pop_ok: rd_ptr increments.
- Latency:
  - A word pushed at edge N is visible on rd_data and empty=0 after edge N (available cycle N+1).
  - Pop-to-next-word: next word visible after the pop edge, in zero extra cycles.
- Pointers: DEPTH_LOG+1 bits internally; the low bits wrap naturally from DEPTH-1 to 0 with no special case.
- count update, registered:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged on both or neither.
- Flags: full = (count == DEPTH), empty = (count == 0); decoded combinationally from the registered count.
- Simultaneous events:
  - Full + wr_en + rd_en: pop accepted, push rejected (full is evaluated before the pop).
  - Empty + wr_en + rd_en: push accepted, pop rejected; no bypass.
  - Non-boundary push+pop: both accepted, count constant.
- Overflow (wr_en while full): ram_we_n stays 1, state unchanged, data dropped.
- Underflow (rd_en while empty): state unchanged; rd_data holds the stale RAM content at rd_ptr and is don't-care to consumers.
- No FSM beyond the pointer/count registers; all outputs except rd_data derive from registers or same-cycle inputs.

Optional Feature:
- Macro: RAM_FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - Adds output ports overflow (1) and underflow (1).
  - Each is a sticky register, set at posedge on wr_en&full or rd_en&empty respectively.
  - Cleared only by rst; reset value 0.
- Undefined: ports absent; overflow/underflow attempts are silently ignored as above.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, ram_we_n=1 on the cycle after reset.
- Push 0xA5, next cycle no ops → rd_data=0xA5, empty=0, count=1; pop → empty=1, count=0.
- Push 16 words 0x00..0x0F → full=1, count=16 after the 16th edge. A 17th push of 0xFF → ram_we_n=1, count stays 16. Pop all → 0x00..0x0F in order, then empty=1.
- Fill to 16, then wr_en=rd_en=1 for one cycle with wr_data=0x77 → count=15, 0x77 not stored, rd_data=0x01.
- Empty FIFO, wr_en=rd_en=1 with 0x3C → count=1, rd_data=0x3C next cycle. Then 40 cycles of simultaneous push/pop of an incrementing pattern → count stays 1, outputs in order, pointers wrap past 15 without error.
- Push 5 words, assert rst for one cycle mid-stream → count=0, empty=1. With RAM_FIFO_CTRL_ERR_FLAGS_EN defined: pop on empty → underflow=1 and stays 1 until rst.
